// File: rtl/shift_ctrl.sv
// shift_ctrl: sequencing controller in front of a universal shift register.
// Takes a parallel word over valid/ready, has the register load it, then
// shifts it out over WIDTH cycles in the requested direction. The bit leaving
// the register in each shift cycle appears on ser_bit, qualified by ser_valid.
module shift_ctrl #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             clear,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic             cmd_dir,
    input  logic [WIDTH-1:0] cmd_data,
    input  logic             cmd_fill,
    input  logic [WIDTH-1:0] sr_q,
    output logic [1:0]       sr_s,
    output logic [WIDTH-1:0] sr_i,
    output logic             sr_msb,
    output logic             sr_lsb,
    output logic             ser_valid,
    output logic             ser_bit,
    output logic             done
);

    // Shift step counter width: ceil(log2(WIDTH)), never below one bit.
    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);

    // Controller states.
    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_LOAD  = 2'd1;
    localparam logic [1:0] ST_SHIFT = 2'd2;
    localparam logic [1:0] ST_DONE  = 2'd3;

    // Register mode-select encodings.
    localparam logic [1:0] MODE_HOLD  = 2'b00;
    localparam logic [1:0] MODE_RIGHT = 2'b01;
    localparam logic [1:0] MODE_LEFT  = 2'b10;
    localparam logic [1:0] MODE_LOAD  = 2'b11;

    logic [1:0]       state;
    logic [1:0]       state_next;
    logic [CW-1:0]    cnt;
    logic             dir_q;
    logic             fill_q;
    logic [WIDTH-1:0] data_q;
    logic             accept;

    // Only the two end bits of the feedback are observed; the rest are
    // collected here so the unused middle bits are explicit.
    logic             unused_sr_q_mid;
    assign unused_sr_q_mid = ^sr_q;

    // A command is taken only while idle; cmd_valid is ignored elsewhere.
    assign accept = (state == ST_IDLE) && cmd_valid;

    // Next-state decision for the load/shift/done sequence.
    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE:  if (accept) state_next = ST_LOAD;
            ST_LOAD:  state_next = ST_SHIFT;
            ST_SHIFT: if (cnt == CNT_LAST) state_next = ST_DONE;
            ST_DONE:  state_next = ST_IDLE;
            default:  state_next = ST_IDLE;
        endcase
    end

    // State register; clear abandons any command in flight.
    always_ff @(posedge clk or negedge clear) begin
        if (!clear) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Shift step counter: zeroed on entry to SHIFT, advanced every shift edge.
    always_ff @(posedge clk or negedge clear) begin
        if (!clear) begin
            cnt <= '0;
        end else if (state == ST_SHIFT) begin
            cnt <= (cnt == CNT_LAST) ? '0 : cnt + CNT_ONE;
        end else begin
            cnt <= '0;
        end
    end

    // Command latch so later changes on cmd_* cannot disturb a running command.
    always_ff @(posedge clk or negedge clear) begin
        if (!clear) begin
            dir_q  <= 1'b0;
            fill_q <= 1'b0;
            data_q <= '0;
        end else if (accept) begin
            dir_q  <= cmd_dir;
            fill_q <= cmd_fill;
            data_q <= cmd_data;
        end
    end

    // Moore output decode from state plus the latched command.
    always_comb begin
        sr_s      = MODE_HOLD;
        sr_msb    = 1'b0;
        sr_lsb    = 1'b0;
        ser_valid = 1'b0;
        ser_bit   = 1'b0;
        done      = 1'b0;
        cmd_ready = 1'b0;
        case (state)
            ST_IDLE: begin
                cmd_ready = 1'b1;
            end
            ST_LOAD: begin
                sr_s = MODE_LOAD;
            end
            ST_SHIFT: begin
                ser_valid = 1'b1;
                if (dir_q) begin
                    sr_s    = MODE_LEFT;
                    sr_lsb  = fill_q;
                    ser_bit = sr_q[WIDTH-1];
                end else begin
                    sr_s    = MODE_RIGHT;
                    sr_msb  = fill_q;
                    ser_bit = sr_q[0];
                end
            end
            ST_DONE: begin
                done = 1'b1;
            end
            default: begin
                sr_s = MODE_HOLD;
            end
        endcase
    end

    // The register only looks at sr_i during a load, so it always shows the latch.
    assign sr_i = data_q;

endmodule

// File: tb/tb_shift_ctrl.sv
// tb_shift_ctrl: drives shift_ctrl with an attached behavioural 4-bit universal
// shift register and checks the serial stream, handshake and register contents
// against a reference built from the bit order each direction produces.
module tb_shift_ctrl;

    localparam int W = 4;

    logic         clk;
    logic         clear;
    logic         cmd_valid;
    logic         cmd_ready;
    logic         cmd_dir;
    logic [W-1:0] cmd_data;
    logic         cmd_fill;
    logic [W-1:0] sr_q;
    logic [1:0]   sr_s;
    logic [W-1:0] sr_i;
    logic         sr_msb;
    logic         sr_lsb;
    logic         ser_valid;
    logic         ser_bit;
    logic         done;

    int total = 0;
    int bad   = 0;

    shift_ctrl #(.WIDTH(W)) dut (
        .clk       (clk),
        .clear     (clear),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_dir   (cmd_dir),
        .cmd_data  (cmd_data),
        .cmd_fill  (cmd_fill),
        .sr_q      (sr_q),
        .sr_s      (sr_s),
        .sr_i      (sr_i),
        .sr_msb    (sr_msb),
        .sr_lsb    (sr_lsb),
        .ser_valid (ser_valid),
        .ser_bit   (ser_bit),
        .done      (done)
    );

    // Free-running clock.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // The attached universal shift register, sharing clk and clear.
    always @(posedge clk or negedge clear) begin
        if (!clear) begin
            sr_q <= '0;
        end else begin
            case (sr_s)
                2'b01:   sr_q <= {sr_msb, sr_q[W-1:1]};
                2'b10:   sr_q <= {sr_q[W-2:0], sr_lsb};
                2'b11:   sr_q <= sr_i;
                default: sr_q <= sr_q;
            endcase
        end
    end

    // Reference bit order: right shifts emit LSB first, left shifts MSB first.
    function automatic logic expBit(input logic [W-1:0] data, input logic dir, input int j);
        logic [W-1:0] word;
        word = data;
        return dir ? word[W-1-j] : word[j];
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // One full command: present it in IDLE, then check every cycle through DONE.
    // After acceptance the cmd_* inputs are replaced by the n* values (either
    // junk to prove they are ignored, or the next command when keepValid=1).
    task automatic applyStimulus(input logic [W-1:0] data, input logic dir, input logic fill,
                                 input logic keepValid, input logic [W-1:0] nData,
                                 input logic nDir, input logic nFill);
        logic [1:0] mode;
        mode = dir ? 2'b10 : 2'b01;
        @(negedge clk);
        cmd_data  = data;
        cmd_dir   = dir;
        cmd_fill  = fill;
        cmd_valid = 1'b1;
        checkOutput("idle_ready", cmd_ready, 1);
        checkOutput("idle_mode", sr_s, 2'b00);
        checkOutput("idle_done", done, 0);
        @(posedge clk);
        @(negedge clk);
        cmd_data  = nData;
        cmd_dir   = nDir;
        cmd_fill  = nFill;
        cmd_valid = keepValid;
        checkOutput("load_mode", sr_s, 2'b11);
        checkOutput("load_data", sr_i, data);
        checkOutput("load_ready", cmd_ready, 0);
        checkOutput("load_valid", ser_valid, 0);
        checkOutput("load_fill", {sr_msb, sr_lsb}, 2'b00);
        for (int j = 0; j < W; j++) begin
            @(negedge clk);
            if (j == 0) checkOutput("reg_loaded", sr_q, data);
            checkOutput("shift_mode", sr_s, mode);
            checkOutput("shift_valid", ser_valid, 1);
            checkOutput("shift_bit", ser_bit, expBit(data, dir, j));
            checkOutput("shift_msb", sr_msb, dir ? 1'b0 : fill);
            checkOutput("shift_lsb", sr_lsb, dir ? fill : 1'b0);
            checkOutput("shift_ready", cmd_ready, 0);
            checkOutput("shift_done", done, 0);
            checkOutput("shift_sri", sr_i, data);
        end
        @(negedge clk);
        checkOutput("done_pulse", done, 1);
        checkOutput("done_mode", sr_s, 2'b00);
        checkOutput("done_ready", cmd_ready, 0);
        checkOutput("done_valid", ser_valid, 0);
        checkOutput("final_reg", sr_q, {W{fill}});
    endtask

    // Stimulus sequence: reset, directed cases, back-to-back, random, abort.
    initial begin
        logic [W-1:0] d;
        logic         dr;
        logic         fl;
        logic         kv;
        logic [W-1:0] nd;
        logic         ndr;
        logic         nfl;

        clear     = 1'b0;
        cmd_valid = 1'b0;
        cmd_dir   = 1'b0;
        cmd_data  = '0;
        cmd_fill  = 1'b0;
        #12;
        checkOutput("rst_ready", cmd_ready, 1);
        checkOutput("rst_mode", sr_s, 2'b00);
        checkOutput("rst_sri", sr_i, 0);
        checkOutput("rst_done", done, 0);
        @(negedge clk);
        clear = 1'b1;

        $display("[TB] directed right and left shifts of 1011");
        applyStimulus(4'b1011, 1'b0, 1'b0, 1'b0, 4'b0100, 1'b1, 1'b1);
        applyStimulus(4'b1011, 1'b1, 1'b1, 1'b0, 4'b0000, 1'b0, 1'b0);

        $display("[TB] back-to-back 0110 then 1001");
        applyStimulus(4'b0110, 1'b0, 1'b1, 1'b1, 4'b1001, 1'b1, 1'b0);
        applyStimulus(4'b1001, 1'b1, 1'b0, 1'b0, 4'b1111, 1'b0, 1'b1);

        $display("[TB] randomized commands");
        for (int n = 0; n < 24; n++) begin
            d   = W'($urandom);
            dr  = 1'($urandom);
            fl  = 1'($urandom);
            kv  = 1'($urandom);
            nd  = W'($urandom);
            ndr = 1'($urandom);
            nfl = 1'($urandom);
            applyStimulus(d, dr, fl, kv, nd, ndr, nfl);
            if (kv) begin
                applyStimulus(nd, ndr, nfl, 1'b0, W'($urandom), 1'($urandom), 1'($urandom));
            end
        end

        $display("[TB] abort after two shift bits");
        @(negedge clk);
        cmd_data  = 4'b1011;
        cmd_dir   = 1'b0;
        cmd_fill  = 1'b1;
        cmd_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        cmd_valid = 1'b0;
        checkOutput("abort_load", sr_s, 2'b11);
        @(negedge clk);
        checkOutput("abort_bit0", ser_bit, 1);
        @(negedge clk);
        checkOutput("abort_bit1", ser_bit, 1);
        @(posedge clk);
        #2;
        clear     = 1'b0;
        cmd_valid = 1'b1;
        #1;
        checkOutput("abort_mode", sr_s, 2'b00);
        checkOutput("abort_valid", ser_valid, 0);
        checkOutput("abort_done", done, 0);
        checkOutput("abort_ready", cmd_ready, 1);
        checkOutput("abort_bit", ser_bit, 0);
        checkOutput("abort_fill", {sr_msb, sr_lsb}, 2'b00);
        checkOutput("abort_sri", sr_i, 0);
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            checkOutput("held_mode", sr_s, 2'b00);
            checkOutput("held_done", done, 0);
        end
        clear     = 1'b1;
        cmd_valid = 1'b0;
        @(negedge clk);
        checkOutput("post_clear_reg", sr_q, 0);
        checkOutput("post_clear_mode", sr_s, 2'b00);
        applyStimulus(4'b1100, 1'b0, 1'b0, 1'b0, 4'b0011, 1'b1, 1'b1);

        @(negedge clk);
        checkOutput("end_ready", cmd_ready, 1);
        checkOutput("end_done", done, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
